fft16_seq_ctrl: RTL and testbench

Frame sequencer for the 16-point radix-4 approximate FFT datapath. It accepts a serial frame of 16 samples into the shared sample buffer, issues the two radix-4 butterfly stages (4 butterflies each) with read, twiddle and writeback controls, and then streams the 16 results out under a valid/ready handshake. It carries no sample data itself. It drives addresses and enables for the buffer and butterfly unit that sit between the serial input and the output stage.

---
 rtl/fft_ctrl_pkg.sv | 34 +++
 rtl/fft_wb_delay.sv | 33 +++
 rtl/fft16_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_fft16_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types, constants and address helpers for the 16-point radix-4 FFT sequencer.
package fft_ctrl_pkg;

    localparam int N             = 16;
    localparam int N_BFLY        = 4;
    localparam int BFLY_LAT_MIN  = 1;
    localparam int BFLY_LAT_MAX  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        S0,
        D0,
        S1,
        D1,
        UNLOAD
    } state_t;

    // Radix-4 digit reversal of a 4-bit index: swaps the two base-4 digits.
    function automatic logic [3:0] digit_rev4(input logic [3:0] c);
        return {c[1:0], c[3:2]};
    endfunction

    // Stage 0 operand j of butterfly k lives at k + 4j.
    function automatic logic [3:0] s0_operand_addr(input logic [1:0] k, input logic [1:0] j);
        return {j, k};
    endfunction

    // Stage 1 operand j of butterfly k lives at 4k + j.
    function automatic logic [3:0] s1_operand_addr(input logic [1:0] k, input logic [1:0] j);
        return {k, j};
    endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-depth delay line carrying {en, stage, idx} from butterfly issue to writeback.
module fft_wb_delay #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       stage_i,
    input  logic [1:0] idx_i,
    output logic       en_o,
    output logic       stage_o,
    output logic [1:0] idx_o
);

    logic [3:0] pipe_q [DEPTH];

    // Reset clears every slot so in-flight writebacks of an aborted frame vanish.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {en_i, stage_i, idx_i};
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {en_o, stage_o, idx_o} = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft16_seq_ctrl.sv
// Frame sequencer for the 16-point radix-4 FFT: load, two butterfly stages, unload.
// Define FFT_CTRL_NATURAL_ORDER_EN to unload in natural (digit-reversed address) order.
module fft16_seq_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int BFLY_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic       bf_rd_en,
    output logic       bf_stage,
    output logic [1:0] bf_idx,
    output logic [1:0] q_flag,
    output logic       wb_en,
    output logic       wb_stage,
    output logic [1:0] wb_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] rd_addr,
    output logic       busy,
    output logic       frame_done
);

    localparam int LAT = (BFLY_LAT < BFLY_LAT_MIN) ? BFLY_LAT_MIN :
                         (BFLY_LAT > BFLY_LAT_MAX) ? BFLY_LAT_MAX : BFLY_LAT;
    localparam logic [3:0] LAST_SAMPLE = 4'(N - 1);
    localparam logic [3:0] LAST_BFLY   = 4'(N_BFLY - 1);
    localparam logic [3:0] LAST_DRAIN  = 4'(LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wr_en_q, wr_en_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic       done_q, done_d;
    logic       issuing;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            done_q    <= done_d;
        end
    end

    // One shared counter serves every state and is zeroed on each state exit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: begin
                if (in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == LAST_SAMPLE) begin
                        state_d = S0;
                        cnt_d   = '0;
                    end
                end
            end
            S0, S1: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_BFLY) begin
                    state_d = (state_q == S0) ? D0 : D1;
                    cnt_d   = '0;
                end
            end
            D0, D1: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_DRAIN) begin
                    state_d = (state_q == D0) ? S1 : UNLOAD;
                    cnt_d   = '0;
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_SAMPLE) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign issuing    = (state_q == S0) || (state_q == S1);
    assign in_ready   = (state_q == LOAD);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign bf_rd_en   = issuing;
    assign bf_stage   = (state_q == S1);
    assign bf_idx     = issuing ? cnt_q[1:0] : 2'd0;
    assign q_flag     = (state_q == S0) ? cnt_q[1:0] : 2'd0;
    assign out_valid  = (state_q == UNLOAD);
    assign busy       = (state_q != IDLE) && (state_q != LOAD);
    assign frame_done = done_q;

`ifdef FFT_CTRL_NATURAL_ORDER_EN
    assign rd_addr = out_valid ? digit_rev4(cnt_q) : 4'd0;
`else
    assign rd_addr = out_valid ? cnt_q : 4'd0;
`endif

    fft_wb_delay #(
        .DEPTH(LAT)
    ) u_wb_delay (
        .clk     (clk),
        .reset   (reset),
        .en_i    (bf_rd_en),
        .stage_i (bf_stage),
        .idx_i   (bf_idx),
        .en_o    (wb_en),
        .stage_o (wb_stage),
        .idx_o   (wb_idx)
    );

endmodule

// File: tb/tb_fft16_seq_ctrl.sv
// Randomized self-checking bench for fft16_seq_ctrl against a frame-timeline reference model.
module tb_fft16_seq_ctrl;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       bf_rd_en;
    logic       bf_stage;
    logic [1:0] bf_idx;
    logic [1:0] q_flag;
    logic       wb_en;
    logic       wb_stage;
    logic [1:0] wb_idx;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] rd_addr;
    logic       busy;
    logic       frame_done;

    fft16_seq_ctrl #(.BFLY_LAT(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .bf_rd_en   (bf_rd_en),
        .bf_stage   (bf_stage),
        .bf_idx     (bf_idx),
        .q_flag     (q_flag),
        .wb_en      (wb_en),
        .wb_stage   (wb_stage),
        .wb_idx     (wb_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model: phase 0 idle, 1 loading, 2 computing (t cycles since first S0), 3 unloading.
    int mPhase, mCnt, mT, expWrEn, expWrAddr, expDone, framesDone, patIdx;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int outOrder(input int c);
`ifdef FFT_CTRL_NATURAL_ORDER_EN
        return (c % 4) * 4 + c / 4;
`else
        return c;
`endif
    endfunction

    task automatic issueAt(input int t, output int en, output int st, output int idx);
        en = 0; st = 0; idx = 0;
        if (t >= 0 && t < 4) begin
            en = 1; idx = t;
        end else if (t >= 4 + L && t < 8 + L) begin
            en = 1; st = 1; idx = t - 4 - L;
        end
    endtask

    task automatic checkResetZero();
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_bf_rd_en", bf_rd_en, 0);
        checkOutput("rst_bf_stage", bf_stage, 0);
        checkOutput("rst_bf_idx", bf_idx, 0);
        checkOutput("rst_q_flag", q_flag, 0);
        checkOutput("rst_wb_en", wb_en, 0);
        checkOutput("rst_wb_stage", wb_stage, 0);
        checkOutput("rst_wb_idx", wb_idx, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_rd_addr", rd_addr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_frame_done", frame_done, 0);
    endtask

    task automatic checkCycle();
        int ie, is, ii, we, ws, wi;
        ie = 0; is = 0; ii = 0; we = 0; ws = 0; wi = 0;
        if (mPhase == 2) begin
            issueAt(mT, ie, is, ii);
            issueAt(mT - L, we, ws, wi);
        end
        checkOutput("in_ready", in_ready, (mPhase == 1) ? 1 : 0);
        checkOutput("wr_en", wr_en, expWrEn);
        if (expWrEn != 0) checkOutput("wr_addr", wr_addr, expWrAddr);
        checkOutput("bf_rd_en", bf_rd_en, ie);
        if (ie != 0) begin
            checkOutput("bf_stage", bf_stage, is);
            checkOutput("bf_idx", bf_idx, ii);
            checkOutput("q_flag", q_flag, (is != 0) ? 0 : ii);
        end
        checkOutput("wb_en", wb_en, we);
        if (we != 0) begin
            checkOutput("wb_stage", wb_stage, ws);
            checkOutput("wb_idx", wb_idx, wi);
        end
        checkOutput("out_valid", out_valid, (mPhase == 3) ? 1 : 0);
        if (mPhase == 3) checkOutput("rd_addr", rd_addr, outOrder(mCnt));
        checkOutput("busy", busy, (mPhase >= 2) ? 1 : 0);
        checkOutput("frame_done", frame_done, expDone);
    endtask

    task automatic applyStimulus(input int ivMode, input int orMode);
        logic [3:0] pattern;
        pattern = 4'b1001;
        in_valid = (ivMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        case (orMode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = pattern[3 - (patIdx % 4)];
                if (mPhase == 3) patIdx++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic advanceModel();
        expWrEn = 0;
        expDone = 0;
        case (mPhase)
            0: begin
                mPhase = 1; mCnt = 0;
            end
            1: if (in_valid) begin
                expWrEn = 1; expWrAddr = mCnt; mCnt++;
                if (mCnt == 16) begin mPhase = 2; mT = 0; end
            end
            2: begin
                mT++;
                if (mT == 8 + 2 * L) begin mPhase = 3; mCnt = 0; end
            end
            default: if (out_ready) begin
                mCnt++;
                if (mCnt == 16) begin
                    expDone = 1; framesDone++; mPhase = 1; mCnt = 0;
                end
            end
        endcase
    endtask

    task automatic resetModel();
        mPhase = 0; mCnt = 0; mT = 0; expWrEn = 0; expWrAddr = 0; expDone = 0; patIdx = 0;
    endtask

    // Runs until the model has counted target frames; abortT >= 0 fires reset at that compute cycle once.
    task automatic runFrames(input int target, input int ivMode, input int orMode, input int abortT);
        int cycles;
        int aborted;
        cycles = 0;
        aborted = 0;
        patIdx = 0;
        while (framesDone < target && cycles < 2000) begin
            checkCycle();
            if (abortT >= 0 && aborted == 0 && mPhase == 2 && mT == abortT) begin
                aborted = 1;
                reset = 1'b1;
                #1;
                checkResetZero();
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                resetModel();
                checkCycle();
            end
            applyStimulus(ivMode, orMode);
            advanceModel();
            @(negedge clk);
            cycles++;
        end
        checkOutput("frames_budget", framesDone, target);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        framesDone = 0;
        resetModel();
        @(negedge clk);
        @(negedge clk);
        checkResetZero();
        reset = 1'b0;
        $display("[TB] back-to-back frame, in_valid held high, out_ready high");
        runFrames(1, 0, 0, -1);
        $display("[TB] random in_valid, out_ready pattern 1,0,0,1");
        runFrames(2, 1, 1, -1);
        $display("[TB] reset during D0, then a normal frame");
        runFrames(3, 0, 0, 4);
        $display("[TB] random in_valid and out_ready");
        runFrames(5, 1, 2, -1);
        repeat (3) begin
            checkCycle();
            applyStimulus(1, 2);
            advanceModel();
            @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
